// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: digit width, FSM states, sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of digit cycles needed for a w-bit operation.
    function automatic int calc_nslice(input int w);
        return w / SLICE_W;
    endfunction

    // Operand width must split evenly into whole digits.
    function automatic bit width_ok(input int w);
        return (w > 0) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/adder_slice3.sv
// 3-bit ripple-carry adder slice: s3 = a3 + b3 + ci, carry out on co.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
module adder_slice3
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a3,
    input  logic [SLICE_W-1:0] b3,
    input  logic               ci,
    output logic [SLICE_W-1:0] s3,
    output logic               co
);

    logic [SLICE_W:0] carry;

    // Full-adder chain, carry rippling from bit 0 upwards.
    always_comb begin
        carry    = '0;
        s3       = '0;
        carry[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            s3[i]       = a3[i] ^ b3[i] ^ carry[i];
            carry[i+1]  = (a3[i] & b3[i]) | (carry[i] & (a3[i] ^ b3[i]));
        end
    end

    assign co = carry[SLICE_W];

endmodule

// File: rtl/adder_seq_slice3.sv
// Digit-serial WIDTH-bit adder reusing one 3-bit slice, one digit per cycle.
// Latency: NSLICE cycles from operand accept to out_valid.
// Backpressure: result held in DONE until out_ready; operands refused outside IDLE.
module adder_seq_slice3
    import adder_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NSLICE - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_chk
            $error("adder_seq_slice3: WIDTH must be a positive multiple of 3");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    adder_slice3 u_slice (
        .a3 (a_q[SLICE_W-1:0]),
        .b3 (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s3 (slice_s),
        .co (slice_co)
    );

    // Outputs decode straight from flops, so no input reaches an output combinationally.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    // Next-state and datapath: load on accept, shift one digit per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                // New digit enters at the top; after NSLICE digits digit 0 sits at bit 0.
                sum_d   = (sum_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
